br_issue_sched: RTL
===================

// Module: br_issue_sched
// PURPOSE
//  Age-ordered issue buffer/scheduler in front of branch_fu. Accepts up to ISSUE_W branch
//  ISSUE_PACKETs/cycle from the issue stage, holds them in a circular buffer, presents the oldest
//  live one to branch_fu each cycle. Applies branch resolution (CLEAR/SQUASH) to stored b_masks.
// PARAMETERS
//  DEPTH    8  buffer entries; power of two, >=2
//  ISSUE_W  2  enqueue lanes per cycle; ISSUE_W <= DEPTH
// PORTS
//  clock        in   1                    system clock
//  reset        in   1                    synchronous, active-high
//  enq_valid    in   ISSUE_W              per-lane enqueue request; lane 0 oldest
//  enq_pack     in   ISSUE_W x ISSUE_PACKET  branch packets, operands resolved
//  free_slots   out  $clog2(DEPTH)+1      DEPTH - (tail - head); upstream gating
//  fu_ready     in   1                    branch_fu accepts this cycle
//  fu_rd_en     out  1                    drives branch_fu rd_en
//  fu_is_pack   out  ISSUE_PACKET         drives branch_fu is_pack
//  rem_br_task  in   BR_TASK              resolution from branch_fu (NOTHING/CLEAR/SQUASH)
//  rem_b_id     in   BR_MASK              one-hot id of resolving branch
//  stat_issued, stat_squashed  out  32    only with BR_SCHED_STATS_EN
//  stat_max_occ                out  $clog2(DEPTH)+1  only with BR_SCHED_STATS_EN
// BEHAVIOUR
//  - Storage: entry[DEPTH] {valid, ISSUE_PACKET}; head, tail ptrs $clog2(DEPTH)+1 bits (wrap bit).
//  - Reset: all valid=0, head=tail=0; free_slots=DEPTH, fu_rd_en=0, fu_is_pack='0, stats=0.
//  - Enqueue: valid lanes compacted in lane order into tail, tail+1...; tail += popcount(enq_valid).
//    Sum of enq_valid > free_slots is illegal (bench asserts); no partial accept.
//  - Select (comb): oldest valid entry scanning head->tail. fu_rd_en = found & fu_ready & !killed.
//    Entry enqueued at edge N is selectable in cycle after N (0-cycle bypass from enq lanes: none).
//  - Dequeue: on fu_rd_en, selected entry valid<=0. Head each cycle advances to first valid entry
//    (after this cycle's dequeue/squash) or to tail if none; holes thus reclaimed.
//  - CLEAR: rem_b_id bit cleared in every stored b_mask, in enq lanes being written, and
//    combinationally in fu_is_pack.decoded_vals.b_mask this cycle.
//  - SQUASH: entries with (b_mask & rem_b_id)!=0 -> valid<=0; matching enq lanes written invalid
//    (slot still consumed, reclaimed by head skip); if selected entry matches, killed=1,
//    fu_rd_en=0 and it is invalidated; no other entry issues that cycle (1 bubble).
//  - Simultaneous enqueue+dequeue+CLEAR/SQUASH all legal same cycle; resolution applied first.
//  - fu_ready=0: nothing dequeued, buffer contents held (resolution still applied).
//  - Full (tail-head==DEPTH): free_slots=0; empty: fu_rd_en=0, fu_is_pack='0.
//  - Pointer wrap: index = ptr[$clog2(DEPTH)-1:0]; full/empty via wrap bit.
//  - Reset mid-operation discards all entries next edge regardless of other inputs.
// CONFIGURATION
//  BR_SCHED_STATS_EN defined: stat_* ports present; stat_issued += fu_rd_en, stat_squashed +=
//  entries invalidated by SQUASH (incl. enq lanes), stat_max_occ = max(tail-head); saturating.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  sys_defs.svh: BR_SCHED_DEPTH, BR_SCHED_ISSUE_W defaults; existing ISSUE_PACKET, BR_TASK, BR_MASK.
//  Sub-module br_sched_oldest_sel: rotate-by-head priority encoder over valid[] -> index + found.
// TESTING
//  1. Reset, enq 2 pkts (PC 0x10,0x14), fu_ready=1 -> issue 0x10 then 0x14 on next 2 cycles.
//  2. Fill 8 entries, fu_ready=0 -> free_slots=0; release -> 8 issues in enq order, free_slots=8.
//  3. Entries b_mask 4'b0010,4'b0001; SQUASH rem_b_id=4'b0010 -> first dropped, only second issues.
//  4. CLEAR rem_b_id=4'b0100 while selected b_mask=4'b0110 -> fu_is_pack b_mask=4'b0010 same cycle.
//  5. Head at idx 6, enq 4 -> wrap to idx 1; SQUASH holes at 6,7 -> head skips, issues idx 0.
//  6. SQUASH matching enq lane 1 same cycle -> lane 1 never issues; stat_squashed +1 (STATS_EN).

Source files
------------

// File: rtl/br_issue_sched_pkg.sv
// Shared types for the branch issue scheduler: packet layout, resolution
// task encoding, branch mask width and default sizing.
package br_issue_sched_pkg;

  localparam int BR_SCHED_DEPTH   = 8;
  localparam int BR_SCHED_ISSUE_W = 2;
  localparam int BR_MASK_W        = 4;

  typedef logic [BR_MASK_W-1:0] BR_MASK;

  typedef enum logic [1:0] {
    BR_NOTHING = 2'd0,
    BR_CLEAR   = 2'd1,
    BR_SQUASH  = 2'd2
  } BR_TASK;

  typedef struct packed {
    BR_MASK     b_mask;
    logic [2:0] br_func;
    logic [4:0] rd;
  } DECODED_VALS;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    DECODED_VALS decoded_vals;
  } ISSUE_PACKET;

  // Saturating 32-bit add used by the statistics counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/br_issue_sched_oldest_sel.sv
// Rotate-by-head priority encoder: returns the first set bit of valid[]
// scanning from head_idx upward with wrap-around.
module br_issue_sched_oldest_sel #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [IW-1:0]    head_idx,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Scan from farthest to nearest so the entry closest to head wins.
  always_comb begin
    logic [IW-1:0] j;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      j = head_idx + IW'(k);
      if (valid[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_issue_sched.sv
// Age-ordered issue buffer in front of branch_fu. Packets are held in a
// circular buffer; the oldest live entry is offered to the unit each cycle
// and branch resolution (CLEAR/SQUASH) is applied to everything stored.
// Optional: define BR_SCHED_STATS_EN for issue/squash/occupancy counters.
module br_issue_sched
  import br_issue_sched_pkg::*;
#(
  parameter int DEPTH   = BR_SCHED_DEPTH,
  parameter int ISSUE_W = BR_SCHED_ISSUE_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ISSUE_W-1:0]         enq_valid,
  input  ISSUE_PACKET                enq_pack [ISSUE_W],
  output logic [$clog2(DEPTH):0]     free_slots,
  input  logic                       fu_ready,
  output logic                       fu_rd_en,
  output ISSUE_PACKET                fu_is_pack,
  input  BR_TASK                     rem_br_task,
  input  BR_MASK                     rem_b_id
`ifdef BR_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_squashed,
  output logic [$clog2(DEPTH):0]     stat_max_occ
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  ISSUE_PACKET        pack_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PW-1:0]      head_q, tail_q;

  ISSUE_PACKET        res_pack [DEPTH];
  logic [DEPTH-1:0]   sq_hit;
  logic               is_clear, is_squash;

  ISSUE_PACKET        lane_pack [ISSUE_W];
  logic [IW-1:0]      lane_idx  [ISSUE_W];
  logic [ISSUE_W-1:0] lane_live;
  logic [ISSUE_W-1:0] lane_sq;
  logic [PW-1:0]      enq_cnt;

  logic [IW-1:0]      sel_idx, nxt_idx;
  logic               sel_found, nxt_found, killed;
  logic [DEPTH-1:0]   valid_after;
  logic [PW-1:0]      tail_next, head_next, occ;

  assign is_clear  = (rem_br_task == BR_CLEAR);
  assign is_squash = (rem_br_task == BR_SQUASH);
  assign occ        = tail_q - head_q;
  assign free_slots = PW'(DEPTH) - occ;

  // Resolution applied to stored entries: mask clear and squash match.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      res_pack[i] = pack_q[i];
      if (is_clear) res_pack[i].decoded_vals.b_mask = pack_q[i].decoded_vals.b_mask & ~rem_b_id;
      sq_hit[i] = is_squash && valid_q[i] && ((pack_q[i].decoded_vals.b_mask & rem_b_id) != '0);
    end
  end

  br_issue_sched_oldest_sel #(.DEPTH(DEPTH)) u_sel_cur (
    .valid    (valid_q),
    .head_idx (head_q[IW-1:0]),
    .idx      (sel_idx),
    .found    (sel_found)
  );

  // Issue the oldest live entry unless the resolving branch kills it.
  always_comb begin
    killed     = sel_found && sq_hit[sel_idx];
    fu_rd_en   = sel_found && fu_ready && !killed;
    fu_is_pack = '0;
    if (sel_found) fu_is_pack = res_pack[sel_idx];
  end

  // Compact valid enqueue lanes into consecutive slots starting at tail.
  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      lane_idx[l]  = tail_q[IW-1:0] + acc[IW-1:0];
      lane_pack[l] = enq_pack[l];
      if (is_clear) lane_pack[l].decoded_vals.b_mask = enq_pack[l].decoded_vals.b_mask & ~rem_b_id;
      lane_sq[l]   = enq_valid[l] && is_squash &&
                     ((enq_pack[l].decoded_vals.b_mask & rem_b_id) != '0);
      lane_live[l] = enq_valid[l] && !lane_sq[l];
      if (enq_valid[l]) acc = acc + PW'(1);
    end
    enq_cnt = acc;
  end

  // Valid vector after this cycle's squash, dequeue and enqueue.
  always_comb begin
    valid_after = valid_q & ~sq_hit;
    if (fu_rd_en) valid_after[sel_idx] = 1'b0;
    for (int l = 0; l < ISSUE_W; l++) begin
      if (enq_valid[l]) valid_after[lane_idx[l]] = lane_live[l];
    end
    tail_next = tail_q + enq_cnt;
  end

  br_issue_sched_oldest_sel #(.DEPTH(DEPTH)) u_sel_nxt (
    .valid    (valid_after),
    .head_idx (head_q[IW-1:0]),
    .idx      (nxt_idx),
    .found    (nxt_found)
  );

  // Head skips holes: jump to the next live entry, or to tail when none remain.
  always_comb begin
    logic [IW-1:0] off;
    off       = nxt_idx - head_q[IW-1:0];
    head_next = nxt_found ? (head_q + {1'b0, off}) : tail_next;
  end

  // Buffer state update: resolution first, then dequeue/enqueue.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pack_q[i] <= res_pack[i];
      for (int l = 0; l < ISSUE_W; l++) begin
        if (enq_valid[l]) pack_q[lane_idx[l]] <= lane_pack[l];
      end
      valid_q <= valid_after;
      head_q  <= head_next;
      tail_q  <= tail_next;
    end
  end

`ifdef BR_SCHED_STATS_EN
  logic [31:0] sq_cnt;

  // Entries removed by a squash this cycle, stored and incoming.
  always_comb begin
    sq_cnt = '0;
    for (int i = 0; i < DEPTH; i++)   sq_cnt = sq_cnt + {31'd0, sq_hit[i]};
    for (int l = 0; l < ISSUE_W; l++) sq_cnt = sq_cnt + {31'd0, lane_sq[l]};
  end

  // Saturating statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issued   <= '0;
      stat_squashed <= '0;
      stat_max_occ  <= '0;
    end else begin
      stat_issued   <= sat_add32(stat_issued, {31'd0, fu_rd_en});
      stat_squashed <= sat_add32(stat_squashed, sq_cnt);
      if (occ > stat_max_occ) stat_max_occ <= occ;
    end
  end
`endif

endmodule
